// File: rtl/linkc_send_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// linkc_send_arbiter_pkg
// Shared flit-format constants, flit type codes, arbiter defaults, FSM state
// type and the head/body flit classifier used by the LinkC send arbiter.
// Optional feature macro used by the arbiter: LINKC_ARB_WDT_EN.
// -----------------------------------------------------------------------------
package linkc_send_arbiter_pkg;

  // Flit format
  localparam int unsigned FLIT_WIDTH      = 32;
  localparam int unsigned XY_WIDTH        = 4;
  localparam int unsigned FLIT_TYPE_WIDTH = 3;
  localparam int unsigned FT_LSB          = XY_WIDTH << 2;

  // Flit type codes; only the two *_BODY codes mark continuation flits
  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_RREQ       = 3'd0;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_WREQ       = 3'd1;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_WDATA_BODY = 3'd2;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_RDATA_HEAD = 3'd3;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_RDATA_BODY = 3'd4;
  localparam logic [FLIT_TYPE_WIDTH-1:0] FT_WRESP      = 3'd5;

  // Arbiter defaults
  localparam int unsigned LC_ARB_WEIGHT       = 4;
  localparam int unsigned LC_ARB_IDLE_HOLD    = 4;
  localparam int unsigned LC_ARB_STARVE_LIMIT = 64;

  // Side encoding for the "served last" register
  localparam logic SIDE_M = 1'b0;
  localparam logic SIDE_S = 1'b1;

  // State encoding doubles as the grant output encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_M = 2'b01,
    ST_GNT_S = 2'b10
  } arb_state_e;

  // Any type code other than the two body codes starts a new packet
  function automatic logic is_head(input logic [FLIT_WIDTH-1:0] flit);
    logic [FLIT_TYPE_WIDTH-1:0] ftype;
    ftype = flit[FT_LSB +: FLIT_TYPE_WIDTH];
    return !((ftype == FT_WDATA_BODY) || (ftype == FT_RDATA_BODY));
  endfunction

endpackage

// File: rtl/linkc_starve_wdt.sv
// -----------------------------------------------------------------------------
// linkc_starve_wdt
// Per-side starvation watchdog: counts cycles a side waits (valid but not
// granted), pulses o_alarm on the cycle the count reaches STARVE_LIMIT and
// then holds o_force until the side is finally granted.
// Only instantiated when LINKC_ARB_WDT_EN is defined.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_wait     side is valid and not currently granted
//   i_clear    side is currently granted (clears count and force)
//   o_alarm    one-cycle pulse on the wait cycle that reaches the limit
//   o_force    asks the current grant to release at its next boundary
// -----------------------------------------------------------------------------
module linkc_starve_wdt #(
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wait,
  input  logic i_clear,
  output logic o_alarm,
  output logic o_force
);

  logic [7:0] r_cnt;
  logic       r_force;
  logic       w_hit;

  // Limit is reached on the wait cycle that would bring the count to the limit
  always_comb begin
    w_hit = 1'b0;
    if (i_wait && !i_clear && (r_cnt == 8'(STARVE_LIMIT - 1))) begin
      w_hit = 1'b1;
    end else begin
      w_hit = 1'b0;
    end
  end

  // Wait counter saturates at the limit so the alarm fires only once per wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 8'd0;
      r_force <= 1'b0;
    end else if (i_clear) begin
      r_cnt   <= 8'd0;
      r_force <= 1'b0;
    end else begin
      if (i_wait && (r_cnt != 8'(STARVE_LIMIT))) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_hit) begin
        r_force <= 1'b1;
      end
    end
  end

  assign o_alarm = w_hit;
  assign o_force = r_force;

endmodule

// File: rtl/linkc_send_arbiter.sv
// -----------------------------------------------------------------------------
// linkc_send_arbiter
// Packet-atomic weighted round-robin arbiter between the MNI and SNI send
// FIFOs (show-ahead) and the shared router send FIFO. One flit per cycle,
// packets never interleave, each grant carries a flit credit that is only
// honoured at packet boundaries.
// Optional feature: define LINKC_ARB_WDT_EN to build the starvation watchdog.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m_flit/m_valid      MNI FIFO head flit and valid; m_deq pops it
//   s_flit/s_valid      SNI FIFO head flit and valid; s_deq pops it
//   sbuf_full           router send FIFO full
//   sbuf_flit/sbuf_we   flit and enqueue strobe to the router send FIFO
//   grant               registered grant, 01=MNI 10=SNI 00=none
//   starve_alarm        one-cycle watchdog pulse (0 without the watchdog)
// -----------------------------------------------------------------------------
module linkc_send_arbiter
  import linkc_send_arbiter_pkg::*;
#(
  parameter int unsigned M_WEIGHT     = LC_ARB_WEIGHT,
  parameter int unsigned S_WEIGHT     = LC_ARB_WEIGHT,
  parameter int unsigned IDLE_HOLD    = LC_ARB_IDLE_HOLD,
  parameter int unsigned STARVE_LIMIT = LC_ARB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] m_flit,
  input  logic                  m_valid,
  output logic                  m_deq,
  input  logic [FLIT_WIDTH-1:0] s_flit,
  input  logic                  s_valid,
  output logic                  s_deq,
  input  logic                  sbuf_full,
  output logic [FLIT_WIDTH-1:0] sbuf_flit,
  output logic                  sbuf_we,
  output logic [1:0]            grant,
  output logic                  starve_alarm
);

  arb_state_e            r_state;
  arb_state_e            w_next_state;
  arb_state_e            w_other;
  logic [3:0]            r_credit;
  logic [3:0]            w_credit_nxt;
  logic [3:0]            r_hold_cnt;
  logic [3:0]            w_hold_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic                  w_gv;
  logic                  w_ov;
  logic                  w_force;
  logic                  w_boundary;
  logic                  w_release;
  logic [FLIT_WIDTH-1:0] w_gflit;
  logic                  w_m_force;
  logic                  w_s_force;

`ifdef LINKC_ARB_WDT_EN
  logic w_m_alarm;
  logic w_s_alarm;

  linkc_starve_wdt #(.STARVE_LIMIT(STARVE_LIMIT)) u_wdt_m (
    .clk     (clk),
    .rst     (rst),
    .i_wait  (m_valid && (r_state != ST_GNT_M)),
    .i_clear (r_state == ST_GNT_M),
    .o_alarm (w_m_alarm),
    .o_force (w_m_force)
  );

  linkc_starve_wdt #(.STARVE_LIMIT(STARVE_LIMIT)) u_wdt_s (
    .clk     (clk),
    .rst     (rst),
    .i_wait  (s_valid && (r_state != ST_GNT_S)),
    .i_clear (r_state == ST_GNT_S),
    .o_alarm (w_s_alarm),
    .o_force (w_s_force)
  );

  assign starve_alarm = w_m_alarm | w_s_alarm;
`else
  assign w_m_force    = 1'b0;
  assign w_s_force    = 1'b0;
  assign starve_alarm = 1'b0;
`endif

  // Steer the granted side's inputs; the force that matters is the one
  // raised by the side currently waiting
  always_comb begin
    w_gv    = 1'b0;
    w_gflit = '0;
    w_ov    = 1'b0;
    w_other = ST_IDLE;
    w_force = 1'b0;
    case (r_state)
      ST_GNT_M: begin
        w_gv    = m_valid;
        w_gflit = m_flit;
        w_ov    = s_valid;
        w_other = ST_GNT_S;
        w_force = w_s_force;
      end
      ST_GNT_S: begin
        w_gv    = s_valid;
        w_gflit = s_flit;
        w_ov    = m_valid;
        w_other = ST_GNT_M;
        w_force = w_m_force;
      end
      default: begin
        w_gv    = 1'b0;
        w_gflit = '0;
        w_ov    = 1'b0;
        w_other = ST_IDLE;
        w_force = 1'b0;
      end
    endcase
  end

  // Next state, transfer strobes and credit/hold bookkeeping
  always_comb begin
    w_next_state = r_state;
    w_credit_nxt = r_credit;
    w_hold_nxt   = r_hold_cnt;
    w_last_nxt   = r_last;
    m_deq        = 1'b0;
    s_deq        = 1'b0;
    sbuf_we      = 1'b0;
    sbuf_flit    = '0;
    w_boundary   = w_gv && is_head(w_gflit);
    // A release cycle never transfers, which is the one-cycle handover bubble
    w_release    = ((r_credit == 4'd0) && w_boundary) ||
                   (!w_gv && (r_hold_cnt == 4'(IDLE_HOLD - 1))) ||
                   (w_force && w_boundary);

    if (r_state == ST_IDLE) begin
      // Tie goes to the side not served last
      if (m_valid && (!s_valid || (r_last == SIDE_S))) begin
        w_next_state = ST_GNT_M;
      end else if (s_valid) begin
        w_next_state = ST_GNT_S;
      end else begin
        w_next_state = ST_IDLE;
      end
    end else begin
      sbuf_flit = w_gflit;
      if (w_release) begin
        w_next_state = w_ov ? w_other : ST_IDLE;
      end else if (w_gv && !sbuf_full) begin
        sbuf_we    = 1'b1;
        w_hold_nxt = 4'd0;
        if (r_state == ST_GNT_M) begin
          m_deq = 1'b1;
        end else begin
          s_deq = 1'b1;
        end
        if (r_credit != 4'd0) begin
          w_credit_nxt = r_credit - 4'd1;
        end else begin
          w_credit_nxt = 4'd0;
        end
      end else if (w_gv) begin
        // Back-pressure: hold everything, nothing leaves the FIFO
        w_hold_nxt = 4'd0;
      end else begin
        w_hold_nxt = r_hold_cnt + 4'd1;
      end
    end

    // Grant entry reloads credit for the newly granted side
    if ((w_next_state != r_state) && (w_next_state == ST_GNT_M)) begin
      w_credit_nxt = 4'(M_WEIGHT);
      w_hold_nxt   = 4'd0;
      w_last_nxt   = SIDE_M;
    end else if ((w_next_state != r_state) && (w_next_state == ST_GNT_S)) begin
      w_credit_nxt = 4'(S_WEIGHT);
      w_hold_nxt   = 4'd0;
      w_last_nxt   = SIDE_S;
    end else begin
      w_last_nxt   = w_last_nxt;
    end
  end

  // State, credit, idle-hold counter and last-served registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_credit   <= 4'd0;
      r_hold_cnt <= 4'd0;
      r_last     <= SIDE_S;
    end else begin
      r_state    <= w_next_state;
      r_credit   <= w_credit_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign grant = r_state;

endmodule

// File: tb/tb_linkc_send_arbiter.sv
// -----------------------------------------------------------------------------
// tb_linkc_send_arbiter
// Directed bench for linkc_send_arbiter: show-ahead FIFO models for the MNI
// and SNI queues, per-cycle checks with hand-computed expectations.
// With LINKC_ARB_WDT_EN defined a second instance exercises the watchdog.
// -----------------------------------------------------------------------------
module tb_linkc_send_arbiter;
  import linkc_send_arbiter_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [FLIT_WIDTH-1:0] m_flit, s_flit, sbuf_flit;
  logic                  m_valid, s_valid, m_deq, s_deq;
  logic                  sbuf_full, sbuf_we, starve_alarm;
  logic [1:0]            grant;

  always #5 clk = ~clk;

  linkc_send_arbiter #(
    .M_WEIGHT(1), .S_WEIGHT(1), .IDLE_HOLD(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_flit(m_flit), .m_valid(m_valid), .m_deq(m_deq),
    .s_flit(s_flit), .s_valid(s_valid), .s_deq(s_deq),
    .sbuf_full(sbuf_full), .sbuf_flit(sbuf_flit), .sbuf_we(sbuf_we),
    .grant(grant), .starve_alarm(starve_alarm)
  );

`ifdef LINKC_ARB_WDT_EN
  logic [FLIT_WIDTH-1:0] wm_flit, ws_flit, w_sbuf_flit;
  logic                  wm_valid, ws_valid, wm_deq, ws_deq, w_sbuf_we, w_alarm;
  logic [1:0]            w_grant;

  linkc_send_arbiter #(
    .M_WEIGHT(15), .S_WEIGHT(1), .IDLE_HOLD(4), .STARVE_LIMIT(8)
  ) dut_w (
    .clk(clk), .rst(rst),
    .m_flit(wm_flit), .m_valid(wm_valid), .m_deq(wm_deq),
    .s_flit(ws_flit), .s_valid(ws_valid), .s_deq(ws_deq),
    .sbuf_full(1'b0), .sbuf_flit(w_sbuf_flit), .sbuf_we(w_sbuf_we),
    .grant(w_grant), .starve_alarm(w_alarm)
  );
`endif

  logic [FLIT_WIDTH-1:0] mq[$];
  logic [FLIT_WIDTH-1:0] sq[$];
  int checks = 0;
  int errors = 0;

  // Outputs sampled mid-cycle (negedge) for the cycle just completed
  logic                  o_we, o_mdeq, o_sdeq, o_alarm;
  logic [1:0]            o_grant;
  logic [FLIT_WIDTH-1:0] o_flit;

  function automatic logic [FLIT_WIDTH-1:0] mk(input logic [2:0] t, input logic [15:0] id);
    logic [FLIT_WIDTH-1:0] f;
    f = '0;
    f[FT_LSB +: FLIT_TYPE_WIDTH] = t;
    f[15:0] = id;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (mq.size() > 0) begin m_valid = 1'b1; m_flit = mq[0]; end
    else begin m_valid = 1'b0; m_flit = '0; end
    if (sq.size() > 0) begin s_valid = 1'b1; s_flit = sq[0]; end
    else begin s_valid = 1'b0; s_flit = '0; end
  endtask

  task automatic cyc();
    @(negedge clk);
    o_we = sbuf_we; o_flit = sbuf_flit; o_grant = grant;
    o_mdeq = m_deq; o_sdeq = s_deq; o_alarm = starve_alarm;
    @(posedge clk);
    #1;
    if (o_mdeq) void'(mq.pop_front());
    if (o_sdeq) void'(sq.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq.delete(); sq.delete();
    sbuf_full = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : main
    logic [FLIT_WIDTH-1:0] t1[6];
    logic [FLIT_WIDTH-1:0] ef[6];
    int                    wc[6];
    logic                  es[6];
    logic                  e_we, e_side;
    logic [FLIT_WIDTH-1:0] e_f;

    // ---- reset state (MNI valid during reset must not be dequeued) ----
    rst = 1'b1; sbuf_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t1[i] = mk((i == 0) ? FT_WREQ : FT_WDATA_BODY, 16'h0100 + 16'(i));
      mq.push_back(t1[i]);
    end
    drive();
    @(posedge clk); #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_we", sbuf_we, 1'b0);
    chk("rst_mdeq", m_deq, 1'b0);
    chk("rst_sdeq", s_deq, 1'b0);
    chk("rst_flit", sbuf_flit, '0);
    chk("rst_alarm", starve_alarm, 1'b0);
    chk("rst_credit", dut.r_credit, 4'd0);
    chk("rst_hold", dut.r_hold_cnt, 4'd0);
    chk("rst_last", dut.r_last, SIDE_S);
    rst = 1'b0;

    // ---- MNI only: head + 5 bodies, written back to back ----
    cyc();
    chk("t1_c0_grant", o_grant, 2'b00);
    chk("t1_c0_we", o_we, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t1_grant", o_grant, 2'b01);
      chk("t1_we", o_we, 1'b1);
      chk("t1_flit", o_flit, t1[i]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_hold_grant", o_grant, 2'b01);
      chk("t1_hold_we", o_we, 1'b0);
    end
    cyc();
    chk("t1_idle_grant", o_grant, 2'b00);

    // ---- tie at reset: 3 single-flit packets per side, weights 1/1 ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mq.push_back(mk(FT_RREQ, 16'h0200 + 16'(i)));
      sq.push_back(mk(FT_RDATA_HEAD, 16'h0300 + 16'(i)));
    end
    drive();
    // Last MNI packet empties its queue, so the final handover waits out the idle hold
    wc = '{1, 3, 5, 7, 9, 14};
    es = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ef = '{mk(FT_RREQ, 16'h0200), mk(FT_RDATA_HEAD, 16'h0300),
           mk(FT_RREQ, 16'h0201), mk(FT_RDATA_HEAD, 16'h0301),
           mk(FT_RREQ, 16'h0202), mk(FT_RDATA_HEAD, 16'h0302)};
    for (int c = 0; c < 16; c++) begin
      cyc();
      e_we = 1'b0; e_f = '0; e_side = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (wc[k] == c) begin e_we = 1'b1; e_f = ef[k]; e_side = es[k]; end
      end
      chk("t2_we", o_we, e_we);
      chk("t2_mdeq", o_mdeq, e_we && !e_side);
      chk("t2_sdeq", o_sdeq, e_we && e_side);
      if (e_we) chk("t2_flit", o_flit, e_f);
    end

    // ---- full stall for cycles 3..7 mid-burst ----
    do_reset();
    for (int i = 0; i < 5; i++) mq.push_back(mk((i == 0) ? FT_WREQ : FT_WDATA_BODY, 16'h0400 + 16'(i)));
    drive();
    cyc();
    cyc(); chk("t3_c1_flit", o_flit, mk(FT_WREQ, 16'h0400));
    cyc(); chk("t3_c2_flit", o_flit, mk(FT_WDATA_BODY, 16'h0401));
    sbuf_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_stall_we", o_we, 1'b0);
      chk("t3_stall_mdeq", o_mdeq, 1'b0);
      chk("t3_stall_grant", o_grant, 2'b01);
      chk("t3_stall_credit", dut.r_credit, 4'd0);
    end
    sbuf_full = 1'b0;
    for (int i = 2; i < 5; i++) begin
      cyc();
      chk("t3_resume_we", o_we, 1'b1);
      chk("t3_resume_flit", o_flit, mk(FT_WDATA_BODY, 16'h0400 + 16'(i)));
    end

    // ---- mid-packet drain with SNI waiting ----
    do_reset();
    mq.push_back(mk(FT_WREQ, 16'h0500));
    mq.push_back(mk(FT_WDATA_BODY, 16'h0501));
    sq.push_back(mk(FT_RREQ, 16'h0600));
    drive();
    cyc(); cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_hold_grant", o_grant, 2'b01);
      chk("t4_hold_sdeq", o_sdeq, 1'b0);
      chk("t4_alarm", o_alarm, 1'b0);
    end
    cyc();
    chk("t4_s_grant", o_grant, 2'b10);
    chk("t4_s_we", o_we, 1'b1);
    chk("t4_s_flit", o_flit, mk(FT_RREQ, 16'h0600));

    // ---- asynchronous reset mid-burst ----
    do_reset();
    for (int i = 0; i < 4; i++) mq.push_back(mk((i == 0) ? FT_WREQ : FT_WDATA_BODY, 16'h0700 + 16'(i)));
    drive();
    cyc(); cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    chk("t5_grant", grant, 2'b00);
    chk("t5_we", sbuf_we, 1'b0);
    chk("t5_credit", dut.r_credit, 4'd0);
    chk("t5_mdeq", m_deq, 1'b0);
    rst = 1'b0;
    sq.push_back(mk(FT_RREQ, 16'h0800));
    drive();
    cyc();
    chk("t5_c0_grant", o_grant, 2'b00);
    cyc();
    chk("t5_tie_grant", o_grant, 2'b01);
    chk("t5_tie_flit", o_flit, mk(FT_WDATA_BODY, 16'h0702));

`ifdef LINKC_ARB_WDT_EN
    // ---- watchdog: MNI streams bodies, SNI waits ----
    wm_valid = 1'b0; ws_valid = 1'b0; wm_flit = '0; ws_flit = '0;
    do_reset();
    wm_valid = 1'b1; wm_flit = mk(FT_WDATA_BODY, 16'h0900);
    ws_valid = 1'b1; ws_flit = mk(FT_RREQ, 16'h0A00);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk("wdt_alarm", w_alarm, (c == 7));
      if (c >= 1) chk("wdt_stream_we", w_sbuf_we, 1'b1);
      @(posedge clk); #1;
    end
    wm_flit = mk(FT_WREQ, 16'h0901);
    @(negedge clk);
    chk("wdt_release_we", w_sbuf_we, 1'b0);
    chk("wdt_release_grant", w_grant, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wdt_s_grant", w_grant, 2'b10);
    chk("wdt_s_flit", w_sbuf_flit, mk(FT_RREQ, 16'h0A00));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
